// File: rtl/radio_sync_pkg.sv
// Shared types and parameter-legality helper for the radio-enable synchroniser bank.
package radio_sync_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ISO     = 2'd1,
        RELEASE = 2'd2
    } iso_state_e;

    function automatic bit sync_params_ok(input int unsigned sync_stages,
                                          input int unsigned filt_cycles,
                                          input int unsigned release_cycles);
        return (sync_stages >= 2) && (filt_cycles >= 1) && (release_cycles >= 1);
    endfunction

endpackage

// File: rtl/radio_enable_filter.sv
// One radio-enable channel: async-input synchroniser followed by a persistence debounce filter.
module radio_enable_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 3
) (
    input  logic ck,
    input  logic arst,
    input  logic d_async,
    output logic filt_next_c
);

    localparam int unsigned CNT_W = $clog2(FILT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   filt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            sync_q <= '0;
            filt   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            filt   <= filt_next_c;
            cnt    <= cnt_next;
        end
    end

    // A new value is accepted only after FILT_CYCLES consecutive disagreeing samples.
    always_comb begin
        filt_next_c = filt;
        cnt_next    = cnt;
        if (sync == filt) begin
            cnt_next = '0;
        end else if (cnt == CNT_TERM) begin
            filt_next_c = sync;
            cnt_next    = '0;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/radio_enable_sync_bank.sv
// Multi-channel radio-enable retiming bank with isolation clamp, release window and edge pulses.
module radio_enable_sync_bank
    import radio_sync_pkg::*;
#(
    parameter int unsigned     NCH            = 4,
    parameter int unsigned     SYNC_STAGES    = 2,
    parameter int unsigned     FILT_CYCLES    = 3,
    parameter logic [NCH-1:0]  ISO_VAL        = '0,
    parameter int unsigned     RELEASE_CYCLES = 4
) (
    input  logic           ck,
    input  logic           arst,
    input  logic           isolate_i,
    input  logic [NCH-1:0] en_async_i,
    output logic [NCH-1:0] en_o,
    output logic [NCH-1:0] rise_o,
    output logic [NCH-1:0] fall_o,
    output logic           iso_active_o
);

    localparam int unsigned REL_W = $clog2(RELEASE_CYCLES + 1);
    localparam logic [REL_W-1:0] REL_TERM = REL_W'(RELEASE_CYCLES - 1);

    if (!sync_params_ok(SYNC_STAGES, FILT_CYCLES, RELEASE_CYCLES)) begin : g_param_check
        $error("radio_enable_sync_bank: illegal SYNC_STAGES/FILT_CYCLES/RELEASE_CYCLES");
    end

    logic [NCH-1:0]   filt_next;
    iso_state_e       state;
    iso_state_e       state_next;
    logic [REL_W-1:0] rel_cnt;
    logic [REL_W-1:0] rel_cnt_next;
    logic [NCH-1:0]   en_next;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        radio_enable_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES)
        ) u_filter (
            .ck          (ck),
            .arst        (arst),
            .d_async     (en_async_i[i]),
            .filt_next_c (filt_next[i])
        );
    end

    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            state        <= RUN;
            rel_cnt      <= '0;
            en_o         <= '0;
            rise_o       <= '0;
            fall_o       <= '0;
            iso_active_o <= 1'b0;
        end else begin
            state        <= state_next;
            rel_cnt      <= rel_cnt_next;
            en_o         <= en_next;
            rise_o       <= en_next & ~en_o;
            fall_o       <= ~en_next & en_o;
            iso_active_o <= (state_next != RUN);
        end
    end

    // Clamp wins over any filter update; RUN is re-entered only after a full quiet window.
    always_comb begin
        state_next   = state;
        rel_cnt_next = rel_cnt;
        en_next      = ISO_VAL;
        unique case (state)
            RUN: begin
                if (isolate_i) begin
                    state_next = ISO;
                end else begin
                    en_next = filt_next;
                end
            end
            ISO: begin
                if (!isolate_i) begin
                    state_next   = RELEASE;
                    rel_cnt_next = '0;
                end
            end
            RELEASE: begin
                if (isolate_i) begin
                    state_next   = ISO;
                    rel_cnt_next = '0;
                end else if (rel_cnt == REL_TERM) begin
                    state_next   = RUN;
                    rel_cnt_next = '0;
                    en_next      = filt_next;
                end else begin
                    rel_cnt_next = rel_cnt + REL_W'(1);
                end
            end
            default: begin
                state_next   = RUN;
                rel_cnt_next = '0;
            end
        endcase
    end

endmodule
